// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage multiply/divide operand, control and result bundle
interface e_mdu_if;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic [31:0] MD_out;
  modport master (output Start, MDOp, A, B, input Busy, HI_out, LO_out, MD_out);
  modport slave  (input Start, MDOp, A, B, output Busy, HI_out, LO_out, MD_out);
endinterface

// File: rtl/e_mdu.sv
// e_mdu: fixed-latency multiply/divide unit with HI/LO; MDU_MADD_EN adds madd/maddu/msub/msubu
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic    Clk,
  input logic    Rst,
  e_mdu_if.slave bus
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic [31:0] a_q, b_q, hi, lo;
  logic start_ok, mul_start, accept, done, write, sgn_div;
  logic [31:0] abs_a, abs_b, da, db, uq, ur, q, r;
  logic [63:0] acc, prod_s, prod_u, res;
`ifdef MDU_MADD_EN
  assign mul_start = bus.MDOp inside {4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12};
`else
  assign mul_start = bus.MDOp inside {4'd1, 4'd2};
`endif
  assign start_ok = mul_start || bus.MDOp inside {4'd3, 4'd4};
  // Next-state logic: accept a valid start in IDLE, retire when the countdown reaches 1
  always_comb begin
    accept  = state == IDLE && bus.Start && start_ok;
    done    = state == BUSY && cnt == CW'(1);
    state_n = accept ? BUSY : done ? IDLE : state;
  end
  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else state <= state_n;
  end
  assign acc    = {hi, lo};
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
  assign sgn_div = op == 4'd3;
  assign abs_a = a_q[31] ? -a_q : a_q;
  assign abs_b = b_q[31] ? -b_q : b_q;
  assign da = sgn_div ? abs_a : a_q;
  assign db = sgn_div ? abs_b : b_q;
  assign uq = da / db;
  assign ur = da % db;
  assign q  = sgn_div && (a_q[31] ^ b_q[31]) ? -uq : uq;
  assign r  = sgn_div && a_q[31] ? -ur : ur;
  assign write = done && !(op inside {4'd3, 4'd4} && b_q == 32'd0);
  // Result select for the retiring operation; magnitude divide gives truncation toward zero
  always_comb begin
    res = acc;
    case (op)
      4'd1: res = prod_s;
      4'd2: res = prod_u;
      4'd3, 4'd4: res = {r, q};
`ifdef MDU_MADD_EN
      4'd9:  res = acc + prod_s;
      4'd10: res = acc + prod_u;
      4'd11: res = acc - prod_s;
      4'd12: res = acc - prod_u;
`endif
      default: res = acc;
    endcase
  end
  // Operand latch, countdown and HI/LO update (mthi/mtlo only honoured in IDLE)
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
      op  <= '0;
      a_q <= '0;
      b_q <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (accept) begin
        cnt <= mul_start ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        op  <= bus.MDOp;
        a_q <= bus.A;
        b_q <= bus.B;
      end else if (state == BUSY) cnt <= cnt - CW'(1);
      if (write) {hi, lo} <= res;
      else if (state == IDLE && bus.MDOp == 4'd5) hi <= bus.A;
      else if (state == IDLE && bus.MDOp == 4'd6) lo <= bus.A;
    end
  end
  assign bus.Busy   = state == BUSY;
  assign bus.HI_out = hi;
  assign bus.LO_out = lo;
  assign bus.MD_out = bus.MDOp == 4'd7 ? hi : bus.MDOp == 4'd8 ? lo : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized self-checking bench for e_mdu against an arithmetic HI/LO model
module tb_e_mdu;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  logic Clk = 0;
  logic Rst = 1;
  int vectors = 0;
  int errors = 0;
  logic [63:0] m_hilo = '0;
  e_mdu_if bus ();
  e_mdu #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;

  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc);
    int sa, sb;
    longint ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    ps = longint'(sa) * longint'(sb);
    pu = {32'b0, a} * {32'b0, b};
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: if (a == 32'h8000_0000 && sb == -1) return {32'h0, 32'h8000_0000};
            else return {32'(sa % sb), 32'(sa / sb)};
      4'd4: return {a % b, a / b};
`ifdef MDU_MADD_EN
      4'd9:  return acc + ps;
      4'd10: return acc + pu;
      4'd11: return acc - ps;
      4'd12: return acc - pu;
`endif
      default: return acc;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int n, lat;
    lat = op inside {4'd3, 4'd4} ? DIV_CYCLES : MULT_CYCLES;
    @(negedge Clk);
    bus.Start = 1; bus.MDOp = op; bus.A = a; bus.B = b;
    #1;
    vectors++;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL %s start_busy got %b want 0", tag, bus.Busy); end
    @(negedge Clk);
    bus.Start = 0; bus.MDOp = 0; bus.A = $urandom; bus.B = $urandom;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin n++; @(negedge Clk); end
    vectors++;
    if (n != lat) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", tag, n, lat); end
    if (!(op inside {4'd3, 4'd4} && b == 0)) m_hilo = ref_res(op, a, b, m_hilo);
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== m_hilo)
      begin errors++; $display("FAIL %s hilo got %h_%h want %h", tag, bus.HI_out, bus.LO_out, m_hilo); end
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    @(negedge Clk);
    bus.MDOp = op; bus.A = a;
    @(negedge Clk);
    bus.MDOp = 0; bus.A = $urandom;
    if (op == 4'd5) m_hilo[63:32] = a;
    else m_hilo[31:0] = a;
  endtask

  task automatic test_reset();
    bus.Start = 0; bus.MDOp = 0; bus.A = 0; bus.B = 0;
    Rst = 1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 0;
    bus.MDOp = 7;
    #1;
    vectors++;
    if (bus.Busy !== 1'b0 || bus.HI_out !== 0 || bus.LO_out !== 0 || bus.MD_out !== 0)
      begin errors++; $display("FAIL reset got busy=%b hi=%h lo=%h md=%h want 0", bus.Busy, bus.HI_out, bus.LO_out, bus.MD_out); end
    bus.MDOp = 0;
    m_hilo = '0;
  endtask

  task automatic test_spec_vectors();
    do_op(4'd1, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_const got %h_%h want ffffffff_ffffffeb", bus.HI_out, bus.LO_out); end
    do_op(4'd2, 32'hFFFF_FFFF, 32'd2, "multu");
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu_const got %h_%h want 00000001_fffffffe", bus.HI_out, bus.LO_out); end
    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg");
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_const got %h_%h want ffffffff_fffffffd", bus.HI_out, bus.LO_out); end
    do_op(4'd4, 32'd7, 32'd0, "divu_zero");
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL divu_zero_const got %h_%h want unchanged", bus.HI_out, bus.LO_out); end
    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf_const got %h_%h want 00000000_80000000", bus.HI_out, bus.LO_out); end
    do_op(4'd3, 32'd5, 32'd0, "div_zero");
  endtask

  task automatic test_move();
    logic [31:0] v;
    move_to(4'd5, 32'h1234);
    bus.MDOp = 7;
    #1;
    vectors++;
    if (bus.MD_out !== 32'h1234) begin errors++; $display("FAIL mfhi got %h want 00001234", bus.MD_out); end
    v = $urandom;
    move_to(4'd6, v);
    bus.MDOp = 8;
    #1;
    vectors++;
    if (bus.MD_out !== v) begin errors++; $display("FAIL mflo got %h want %h", bus.MD_out, v); end
    bus.MDOp = 0;
    #1;
    vectors++;
    if (bus.MD_out !== 0) begin errors++; $display("FAIL md_none got %h want 0", bus.MD_out); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b;
    int n;
    a = $urandom; b = $urandom | 32'h1;
    @(negedge Clk);
    bus.Start = 1; bus.MDOp = 3; bus.A = a; bus.B = b;
    @(negedge Clk);
    bus.Start = 0; bus.MDOp = 0; bus.A = $urandom; bus.B = $urandom;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      bus.Start = n == 2; bus.MDOp = n == 2 ? 4'd2 : n == 3 ? 4'd6 : n == 4 ? 4'd5 : 4'd0; bus.A = $urandom;
      @(negedge Clk);
    end
    bus.Start = 0; bus.MDOp = 0;
    m_hilo = ref_res(4'd3, a, b, m_hilo);
    vectors++;
    if (n != DIV_CYCLES) begin errors++; $display("FAIL busy_ignore cycles got %0d want %0d", n, DIV_CYCLES); end
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== m_hilo) begin errors++; $display("FAIL busy_ignore hilo got %h_%h want %h", bus.HI_out, bus.LO_out, m_hilo); end
    @(negedge Clk);
    vectors++;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL busy_ignore restart got %b want 0", bus.Busy); end
  endtask

  task automatic test_invalid_start();
    logic [3:0] codes [3] = '{4'd7, 4'd13, 4'd0};
    foreach (codes[i]) begin
      @(negedge Clk);
      bus.Start = 1; bus.MDOp = codes[i]; bus.A = $urandom; bus.B = $urandom;
      @(negedge Clk);
      bus.Start = 0; bus.MDOp = 0;
      vectors++;
      if (bus.Busy !== 1'b0 || {bus.HI_out, bus.LO_out} !== m_hilo)
        begin errors++; $display("FAIL invalid_start op=%0d got busy=%b hilo=%h_%h want 0 %h", codes[i], bus.Busy, bus.HI_out, bus.LO_out, m_hilo); end
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
`ifdef MDU_MADD_EN
      op = $urandom_range(0, 2) == 0 ? 4'($urandom_range(9, 12)) : 4'($urandom_range(1, 4));
`else
      op = 4'($urandom_range(1, 4));
`endif
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 5) == 0) b = 0;
      if ($urandom_range(0, 7) == 0) b = $urandom_range(1, 9);
      if (i == 5) begin op = 4'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      do_op(op, a, b, "random");
    end
  endtask

  task automatic test_reset_abort();
    @(negedge Clk);
    bus.Start = 1; bus.MDOp = 3; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge Clk);
    bus.Start = 0; bus.MDOp = 0;
    repeat (2) @(negedge Clk);
    Rst = 1;
    @(negedge Clk);
    Rst = 0;
    m_hilo = '0;
    vectors++;
    if (bus.Busy !== 1'b0 || bus.HI_out !== 0 || bus.LO_out !== 0)
      begin errors++; $display("FAIL reset_abort got busy=%b hi=%h lo=%h want 0", bus.Busy, bus.HI_out, bus.LO_out); end
    repeat (DIV_CYCLES) @(negedge Clk);
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== 64'h0) begin errors++; $display("FAIL reset_abort_late got %h_%h want 0", bus.HI_out, bus.LO_out); end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    move_to(4'd5, 32'd0);
    move_to(4'd6, 32'd10);
    do_op(4'd9, 32'd2, 32'd3, "madd");
    vectors++;
    if (bus.LO_out !== 32'd16) begin errors++; $display("FAIL madd_const got %h want 00000010", bus.LO_out); end
    do_op(4'd12, 32'd1, 32'd17, "msubu");
    vectors++;
    if ({bus.HI_out, bus.LO_out} !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL msubu_const got %h_%h want all ones", bus.HI_out, bus.LO_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_spec_vectors();
    test_move();
    test_busy_ignore();
    test_invalid_start();
    test_random();
    test_reset_abort();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
